// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared definitions for the stall-trace run-length encoder.
//   - bp_stall_reason_e     : stall reason enum, values 0..23
//   - bp_stall_code_instret : code used for a cycle that retired an instruction
//   - bp_stall_code()       : maps a raw sample onto the 5-bit trace code
//   - `BP_BE_STALL_RLE_REC_S(cw) : record struct {code[4:0], run[cw-1:0]}
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define BP_BE_STALL_RLE_REC_S(cw) struct packed { logic [4:0] code; logic [(cw)-1:0] run; }

package bp_be_pkg;

    typedef enum logic [4:0] {
        e_stall_unknown         = 5'd0,
        e_stall_fe_queue        = 5'd1,
        e_stall_fe_wait         = 5'd2,
        e_stall_itlb_miss       = 5'd3,
        e_stall_icache_miss     = 5'd4,
        e_stall_icache_fence    = 5'd5,
        e_stall_branch_override = 5'd6,
        e_stall_ret_override    = 5'd7,
        e_stall_fe_cmd          = 5'd8,
        e_stall_fe_cmd_fence    = 5'd9,
        e_stall_mispredict      = 5'd10,
        e_stall_control_haz     = 5'd11,
        e_stall_long_haz        = 5'd12,
        e_stall_data_haz        = 5'd13,
        e_stall_aux_dep         = 5'd14,
        e_stall_load_dep        = 5'd15,
        e_stall_mul_dep         = 5'd16,
        e_stall_fma_dep         = 5'd17,
        e_stall_sb_dep          = 5'd18,
        e_stall_struct_haz      = 5'd19,
        e_stall_dtlb_miss       = 5'd20,
        e_stall_dcache_miss     = 5'd21,
        e_stall_exception       = 5'd22,
        e_stall_interrupt       = 5'd23
    } bp_stall_reason_e;

    localparam logic [4:0] bp_stall_code_instret = 5'd24;
    localparam logic [4:0] bp_stall_reason_max   = 5'd23;

    // Out-of-range reasons collapse onto "unknown" so the code space stays 0..24.
    function automatic logic [4:0] bp_stall_code(input logic instret, input logic [4:0] reason);
        if (instret)                          return bp_stall_code_instret;
        else if (reason > bp_stall_reason_max) return e_stall_unknown;
        else                                  return reason;
    endfunction

endpackage

`endif

// File: rtl/bp_be_stall_trace_rle_if.sv
// bp_be_stall_trace_rle_if: ready/valid record stream toward the trace sink.
//   data_o  : record {code, run (, start_cycle)}, code in MSBs
//   v_o     : record valid
//   ready_i : sink accepts data_o when v_o & ready_i
// Signal names are from the encoder's point of view (master drives _o).
interface bp_be_stall_trace_rle_if #(parameter int data_width_p = 17);
    logic [data_width_p-1:0] data_o;
    logic                    v_o;
    logic                    ready_i;

    modport master (output data_o, v_o, input ready_i);
    modport slave  (input data_o, v_o, output ready_i);
endinterface

// File: rtl/bp_be_stall_rle_accum.sv
// bp_be_stall_rle_accum: IDLE/RUN run-length accumulator.
//   clk_i, reset_n_i (synchronous, active low)
//   s_v_i, code_i  : qualified sample and its 5-bit code
//   flush_i        : close the open run
//   emit_v_o       : a record is emitted this cycle (at most one)
//   emit_data_o    : {code, run}
//   run_start_o    : a new run begins with this cycle's sample
module bp_be_stall_rle_accum
    import bp_be_pkg::*;
  #(parameter int count_width_p = 12)
   (input  logic                     clk_i
  , input  logic                     reset_n_i
  , input  logic                     s_v_i
  , input  logic [4:0]               code_i
  , input  logic                     flush_i
  , output logic                     emit_v_o
  , output logic [4+count_width_p:0] emit_data_o
  , output logic                     run_start_o);

    typedef `BP_BE_STALL_RLE_REC_S(count_width_p) rec_t;
    typedef enum logic {e_idle, e_run} state_e;

    localparam logic [count_width_p-1:0] cnt_one_lp = count_width_p'(1);

    state_e                   state_q, state_d;
    logic [4:0]               run_code_q, run_code_d;
    logic [count_width_p-1:0] run_cnt_q, run_cnt_d;
    logic                     same, at_max;
    rec_t                     rec;

    assign same   = (code_i == run_code_q);
    assign at_max = (run_cnt_q == '1);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            run_code_q <= '0;
            run_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_code_q <= run_code_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_code_d = run_code_q;
        run_cnt_d  = run_cnt_q;
        unique case (state_q)
            e_idle: begin
                if (s_v_i) begin
                    state_d    = e_run;
                    run_code_d = code_i;
                    run_cnt_d  = cnt_one_lp;
                end
            end
            e_run: begin
                if (flush_i) begin
                    if (s_v_i && same && !at_max) begin
                        // Sample folds into the closing record.
                        state_d   = e_idle;
                        run_cnt_d = '0;
                    end else if (s_v_i) begin
                        // Closing record goes out; sample opens the next run.
                        run_code_d = code_i;
                        run_cnt_d  = cnt_one_lp;
                    end else begin
                        state_d   = e_idle;
                        run_cnt_d = '0;
                    end
                end else if (s_v_i && (!same || at_max)) begin
                    run_code_d = code_i;
                    run_cnt_d  = cnt_one_lp;
                end else if (s_v_i) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        emit_v_o    = 1'b0;
        run_start_o = 1'b0;
        rec.code    = run_code_q;
        rec.run     = run_cnt_q;
        unique case (state_q)
            e_idle: run_start_o = s_v_i;
            e_run: begin
                if (flush_i) begin
                    emit_v_o = 1'b1;
                    if (s_v_i && same && !at_max) rec.run = run_cnt_q + 1'b1;
                    else                          run_start_o = s_v_i;
                end else if (s_v_i && (!same || at_max)) begin
                    emit_v_o    = 1'b1;
                    run_start_o = 1'b1;
                end
            end
            default: ;
        endcase
        emit_data_o = rec;
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small register-based FIFO, one enqueue and one dequeue per cycle.
//   clk_i, reset_i (synchronous, active high)
//   v_i/ready_o/data_i : enqueue side; ready_o reflects occupancy at cycle start only
//   v_o/data_o/yumi_i  : dequeue side; data_o is zero while empty
// els_p must be a power of two so the pointers wrap naturally.
module bsg_fifo_1r1w_small
  #(parameter int width_p = 17
  , parameter int els_p   = 8)
   (input  logic               clk_i
  , input  logic               reset_i
  , input  logic               v_i
  , output logic               ready_o
  , input  logic [width_p-1:0] data_i
  , output logic               v_o
  , output logic [width_p-1:0] data_o
  , input  logic               yumi_i);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam logic [ptr_w_lp:0] full_cnt_lp = (ptr_w_lp+1)'(els_p);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, rptr_q;
    logic [ptr_w_lp:0]   cnt_q;
    logic                enq, deq;

    // A same-cycle dequeue does not make room: full is judged from cnt_q alone.
    assign ready_o = (cnt_q != full_cnt_lp);
    assign v_o     = (cnt_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = v_o ? mem_q[rptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq) wptr_q <= wptr_q + 1'b1;
            if (deq) rptr_q <= rptr_q + 1'b1;
            case ({enq, deq})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_be_stall_trace_rle.sv
// bp_be_stall_trace_rle: run-length encoder for the per-cycle commit/stall stream.
//   clk_i, reset_n_i (synchronous, active low)
//   freeze_i, v_i, instret_i, reason_i : per-cycle sample from the stall profiler
//   flush_i       : close the open run and emit it
//   trace         : record stream (data_o / v_o / ready_i), master side
//   overflow_o    : sticky, a record was dropped on a full FIFO
//   drop_count_o  : number of dropped records, saturating
// Optional: define BP_STALL_TRACE_RLE_TIMESTAMP_EN to append a 30-bit start_cycle
// (free-running cycle count at the run's first sample) to each record's LSBs.
module bp_be_stall_trace_rle
    import bp_be_pkg::*;
  #(parameter int count_width_p = 12
  , parameter int fifo_els_p    = 8
  , parameter int drop_width_p  = 16)
   (input  logic                    clk_i
  , input  logic                    reset_n_i
  , input  logic                    freeze_i
  , input  logic                    v_i
  , input  logic                    instret_i
  , input  logic [4:0]              reason_i
  , input  logic                    flush_i
  , bp_be_stall_trace_rle_if.master trace
  , output logic                    overflow_o
  , output logic [drop_width_p-1:0] drop_count_o);

    localparam int rec_width_lp = 5 + count_width_p;
`ifdef BP_STALL_TRACE_RLE_TIMESTAMP_EN
    localparam int data_width_lp = rec_width_lp + 30;
`else
    localparam int data_width_lp = rec_width_lp;
`endif

    logic                     s_v;
    logic [4:0]               code;
    logic                     emit_v;
    logic [rec_width_lp-1:0]  emit_data;
    logic [data_width_lp-1:0] fifo_data_li;
    logic                     fifo_ready;
    logic [drop_width_p-1:0]  drop_q;
    logic                     ovf_q;

    assign s_v  = v_i & ~freeze_i;
    assign code = bp_stall_code(instret_i, reason_i);

`ifdef BP_STALL_TRACE_RLE_TIMESTAMP_EN
    logic        run_start;
    logic [29:0] cycle_q, start_q;

    // Counts frozen cycles too; wraps at 2**30.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cycle_q <= '0;
            start_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (run_start) start_q <= cycle_q;
        end
    end

    // start_q still holds the closing run's start when its record is emitted.
    assign fifo_data_li = {emit_data, start_q};
`else
    logic unused_run_start;
    assign fifo_data_li = emit_data;
`endif

    bp_be_stall_rle_accum #(.count_width_p(count_width_p)) accum (
        .clk_i       (clk_i)
      , .reset_n_i   (reset_n_i)
      , .s_v_i       (s_v)
      , .code_i      (code)
      , .flush_i     (flush_i)
      , .emit_v_o    (emit_v)
      , .emit_data_o (emit_data)
`ifdef BP_STALL_TRACE_RLE_TIMESTAMP_EN
      , .run_start_o (run_start)
`else
      , .run_start_o (unused_run_start)
`endif
    );

    bsg_fifo_1r1w_small #(.width_p(data_width_lp), .els_p(fifo_els_p)) fifo (
        .clk_i   (clk_i)
      , .reset_i (~reset_n_i)
      , .v_i     (emit_v)
      , .ready_o (fifo_ready)
      , .data_i  (fifo_data_li)
      , .v_o     (trace.v_o)
      , .data_o  (trace.data_o)
      , .yumi_i  (trace.v_o & trace.ready_i)
    );

    // Accumulator never stalls; a record that finds the FIFO full is counted and lost.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else if (emit_v && !fifo_ready) begin
            ovf_q <= 1'b1;
            if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    assign overflow_o   = ovf_q;
    assign drop_count_o = drop_q;

endmodule

// File: doc/bp_be_stall_trace_rle.md
Name: bp_be_stall_trace_rle

Overview:
- Synthesizable run-length encoder for the per-cycle commit/stall classification stream produced by the core stall profiler. Sits directly downstream of it.
- Each cycle yields one 5-bit code: the stall reason enum (0..23), or 24 when an instruction retired.
- Consecutive identical codes merge into {code, run_length} records. Records are buffered in a small FIFO and drained over ready/valid to a trace sink (DMA or host port).
- Cuts trace bandwidth versus one line per cycle.

Parameters:
count_width_p, 12, run-length field width; max run = 2**count_width_p-1
fifo_els_p, 8, record FIFO depth (power of 2, >=2)
drop_width_p, 16, width of saturating drop counter

Ports:
clk_i  in  1  clock, all logic posedge
reset_n_i  in  1  synchronous active-low reset
freeze_i  in  1  core frozen; input sample ignored
v_i  in  1  cycle sample valid
instret_i  in  1  instruction retired this cycle
reason_i  in  5  stall reason enum; ignored when instret_i=1
flush_i  in  1  close the open run and emit it
data_o  out  5+count_width_p (+30 with timestamp)  record {code[4:0], run[count_width_p-1:0] (, start_cycle[29:0])}, code in MSBs
v_o  out  1  record valid
ready_i  in  1  sink accepts data_o when v_o&ready_i
overflow_o  out  1  sticky: a record has been dropped
drop_count_o  out  drop_width_p  dropped records, saturating

Behaviour:
- Sample: s_v = v_i & ~freeze_i. code = instret_i ? 5'd24 : reason_i. reason_i > 23 with instret_i=0 maps to 0 (unknown).
- Accumulator states are IDLE and RUN, with regs run_code and run_cnt.
- IDLE:
  - s_v=1 -> RUN, run_code=code, run_cnt=1.
  - flush_i alone -> no record.
- RUN, in priority order:
  1. flush_i=1:
     - If s_v and code==run_code and run_cnt<max: emit {run_code, run_cnt+1}, then IDLE.
     - If s_v otherwise: emit {run_code, run_cnt}. Only one record is emitted per cycle. A new run starts with code, cnt=1, and the state stays RUN.
     - If !s_v: emit {run_code, run_cnt}, then IDLE.
  2. s_v and code!=run_code: emit {run_code, run_cnt}, start new run (code, 1).
  3. s_v and code==run_code and run_cnt==max: emit {run_code, max}, start new run (code, 1).
  4. s_v and same code: run_cnt+1.
  5. !s_v: hold. Gaps do not split runs.
- At most one emit per cycle.
- Emit pushes into the FIFO only if the FIFO is not full at the start of the cycle. A simultaneous dequeue does not free space for the same cycle.
- On a full FIFO:
  - The record is discarded.
  - drop_count_o increments, saturating at all-ones.
  - overflow_o sets.
  - The accumulator proceeds as if the record had been accepted.
- Latency: an emitted record is visible on v_o the cycle after the emitting sample.
- FIFO is first-in first-out. data_o is stable while v_o=1 and ready_i=0.
- Reset (reset_n_i=0 at posedge):
  - State returns to IDLE, FIFO empties, run_cnt=0.
  - Outputs: v_o=0, overflow_o=0, drop_count_o=0, data_o=0.
  - An open run is discarded, not emitted. Reset overrides all other inputs in the same cycle.
- freeze_i has no effect on draining the FIFO.

Optional Feature:
- Macro: BP_STALL_TRACE_RLE_TIMESTAMP_EN.
- When defined:
  - A 30-bit free-running cycle counter is instantiated. It resets to 0, wraps at 2**30, and counts every cycle, including frozen ones.
  - The counter value at the cycle a run starts is latched and appended to the record LSBs as start_cycle.
  - data_o width is 35+count_width_p.
- When undefined: no counter, and data_o is 5+count_width_p wide.

Decomposition:
- Shared package bp_be_pkg gets:
  - the stall-reason enum with values 0..23
  - a constant bp_stall_code_instret=5'd24
  - a record struct macro parameterized by count_width_p
- One sub-module, bp_be_stall_rle_accum: the IDLE/RUN accumulator, producing emit_v and emit_data.
- Top instantiates the accumulator and bsg_fifo_1r1w_small, and owns the drop counter and optional timestamp.

Test Plan:
- Sample sequence 24,24,24,6,6 then flush_i, with ready_i=1 -> records {24,3} then {6,2}; each record v_o one cycle after its emit.
- count_width_p=3, code 11 held for 9 cycles then flush_i -> {11,7} then {11,2}.
- ready_i=0, fifo_els_p=8, 10 alternating codes 3,4,3,4... -> 8 records buffered. Next emits dropped: drop_count_o=1 after 9th, 2 after 10th (also on flush_i). overflow_o=1. Raising ready_i drains 8 records in order.
- Samples 5,5, then v_i=0 for 4 cycles, then freeze_i=1 with v_i=1 code 7 for 3 cycles, then 5 -> a single open run {5,3} with no record emitted.
- Reset asserted mid-run with records in the FIFO -> next cycle: v_o=0, drop_count_o=0, overflow_o=0; no stale record ever appears.
- With BP_STALL_TRACE_RLE_TIMESTAMP_EN: reset release at cycle 0, code 13 starts at counter 4 and runs 3 cycles, then code 24 -> record {13,3,start_cycle=4}.
